ex_operand_stage: RTL and testbench

ID/EX pipeline register and operand-select stage. It sits directly upstream of the ALU and produces its alu_op, r1 and r2 one cycle before the ALU registers its result.
- Captures decoded instruction fields from decode.
- Resolves RAW hazards by forwarding from the EX and MEM stages.
- Detects load-use hazards and inserts bubbles.
- Honours downstream stall and branch flush.

---
 rtl/ex_operand_stage.sv | 152 +++++++++++++++
 tb/tb_ex_operand_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX pipeline register with operand select.
// Captures decoded fields, resolves RAW hazards and inserts bubbles for
// dependencies that cannot be satisfied this cycle.
// Macro FWD_EN: when defined, EX/MEM results are forwarded into r1/r2 and
// only load-use dependencies stall; when undefined, operands come from the
// register file only and any dependency on an in-flight writer stalls.
module ex_operand_stage #(
   parameter int         XLEN    = 32,
   parameter int         RAW     = 5,
   parameter logic [4:0] ALU_NOP = 5'h1F
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4:0]      in_alu_op,
   input  logic [RAW-1:0]  in_rs1,
   input  logic [RAW-1:0]  in_rs2,
   input  logic [RAW-1:0]  in_rd,
   input  logic [XLEN-1:0] in_rs1_val,
   input  logic [XLEN-1:0] in_rs2_val,
   input  logic [XLEN-1:0] in_imm,
   input  logic [XLEN-1:0] in_pc,
   input  logic            in_a_sel,
   input  logic            in_b_sel,
   input  logic            in_wb_en,
   input  logic            ex_fwd_en,
   input  logic [RAW-1:0]  ex_fwd_rd,
   input  logic [XLEN-1:0] ex_fwd_val,
   input  logic            ex_is_load,
   input  logic            mem_fwd_en,
   input  logic [RAW-1:0]  mem_fwd_rd,
   input  logic [XLEN-1:0] mem_fwd_val,
   input  logic            ex_stall,
   input  logic            flush,
   output logic [4:0]      alu_op,
   output logic [XLEN-1:0] r1,
   output logic [XLEN-1:0] r2,
   output logic            out_valid,
   output logic [RAW-1:0]  out_rd,
   output logic            out_wb_en,
   output logic [XLEN-1:0] out_pc,
   output logic            bubble
);

   logic [4:0]      r_alu_op;
   logic [XLEN-1:0] r_r1, r_r2, r_pc;
   logic            r_valid, r_wb_en, r_bubble;
   logic [RAW-1:0]  r_rd;

   // x0 is never a real dependency, and an operand replaced by pc/imm is unused
   logic w_use1, w_use2;
   assign w_use1 = !in_a_sel && (in_rs1 != '0);
   assign w_use2 = !in_b_sel && (in_rs2 != '0);

   logic [XLEN-1:0] w_fwd1, w_fwd2;
   logic            w_hazard;

`ifdef FWD_EN
   // A load in EX has no data yet, so it is excluded from EX forwarding
   logic w_ex_hit1, w_ex_hit2, w_mem_hit1, w_mem_hit2;
   assign w_ex_hit1  = ex_fwd_en && !ex_is_load && (ex_fwd_rd == in_rs1);
   assign w_ex_hit2  = ex_fwd_en && !ex_is_load && (ex_fwd_rd == in_rs2);
   assign w_mem_hit1 = mem_fwd_en && (mem_fwd_rd == in_rs1);
   assign w_mem_hit2 = mem_fwd_en && (mem_fwd_rd == in_rs2);

   // Youngest writer wins: EX before MEM before register file
   assign w_fwd1 = (in_rs1 == '0) ? '0 :
                   w_ex_hit1 ? ex_fwd_val : w_mem_hit1 ? mem_fwd_val : in_rs1_val;
   assign w_fwd2 = (in_rs2 == '0) ? '0 :
                   w_ex_hit2 ? ex_fwd_val : w_mem_hit2 ? mem_fwd_val : in_rs2_val;

   assign w_hazard = ex_fwd_en && ex_is_load && (ex_fwd_rd != '0) &&
                     ((w_use1 && ex_fwd_rd == in_rs1) || (w_use2 && ex_fwd_rd == in_rs2));
`else
   // No bypass network: wait until every in-flight writer has retired
   logic w_ex_dep, w_mem_dep;
   assign w_ex_dep  = ex_fwd_en && (ex_fwd_rd != '0) &&
                      ((w_use1 && ex_fwd_rd == in_rs1) || (w_use2 && ex_fwd_rd == in_rs2));
   assign w_mem_dep = mem_fwd_en && (mem_fwd_rd != '0) &&
                      ((w_use1 && mem_fwd_rd == in_rs1) || (w_use2 && mem_fwd_rd == in_rs2));
   assign w_hazard  = w_ex_dep || w_mem_dep;

   assign w_fwd1 = (in_rs1 == '0) ? '0 : in_rs1_val;
   assign w_fwd2 = (in_rs2 == '0) ? '0 : in_rs2_val;

   logic w_unused;
   assign w_unused = ^{ex_fwd_val, mem_fwd_val, ex_is_load};
`endif

   assign in_ready = !rst && !ex_stall && !w_hazard;

   // Pipeline register: reset > flush > stall > hazard bubble > issue > idle bubble
   always_ff @(posedge clk) begin
      if (rst) begin
         r_alu_op <= ALU_NOP;
         r_r1     <= '0;
         r_r2     <= '0;
         r_valid  <= 1'b0;
         r_rd     <= '0;
         r_wb_en  <= 1'b0;
         r_pc     <= '0;
         r_bubble <= 1'b0;
      end else if (flush) begin
         r_alu_op <= ALU_NOP;
         r_r1     <= '0;
         r_r2     <= '0;
         r_valid  <= 1'b0;
         r_rd     <= '0;
         r_wb_en  <= 1'b0;
         r_bubble <= 1'b0;
      end else if (ex_stall) begin
         // ALU-facing state is frozen; no new bubble is inserted while stalled
         r_bubble <= 1'b0;
      end else if (in_valid && w_hazard) begin
         r_alu_op <= ALU_NOP;
         r_r1     <= '0;
         r_r2     <= '0;
         r_valid  <= 1'b0;
         r_rd     <= '0;
         r_wb_en  <= 1'b0;
         r_bubble <= 1'b1;
      end else if (in_valid) begin
         r_alu_op <= in_alu_op;
         r_r1     <= in_a_sel ? in_pc  : w_fwd1;
         r_r2     <= in_b_sel ? in_imm : w_fwd2;
         r_valid  <= 1'b1;
         r_rd     <= in_rd;
         r_wb_en  <= in_wb_en;
         r_pc     <= in_pc;
         r_bubble <= 1'b0;
      end else begin
         r_alu_op <= ALU_NOP;
         r_r1     <= '0;
         r_r2     <= '0;
         r_valid  <= 1'b0;
         r_rd     <= '0;
         r_wb_en  <= 1'b0;
         r_bubble <= 1'b0;
      end
   end

   assign alu_op    = r_alu_op;
   assign r1        = r_r1;
   assign r2        = r_r2;
   assign out_valid = r_valid;
   assign out_rd    = r_rd;
   assign out_wb_en = r_wb_en;
   assign out_pc    = r_pc;
   assign bubble    = r_bubble;

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage: scoreboard bench for ex_operand_stage.
// Accepted instructions push their expected ALU inputs; a monitor pops and
// compares whenever a fresh result appears. Works with or without FWD_EN.
module tb_ex_operand_stage;
   localparam logic [4:0] NOP = 5'h1F;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, in_a_sel, in_b_sel, in_wb_en;
   logic [4:0]  in_alu_op, in_rs1, in_rs2, in_rd, ex_fwd_rd, mem_fwd_rd, alu_op, out_rd;
   logic [31:0] in_rs1_val, in_rs2_val, in_imm, in_pc, ex_fwd_val, mem_fwd_val, r1, r2, out_pc;
   logic        ex_fwd_en, ex_is_load, mem_fwd_en, ex_stall, flush;
   logic        out_valid, out_wb_en, bubble;

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a, b;
      logic [4:0]  rd;
      logic        wb;
      logic [31:0] pc;
   } exp_t;
   exp_t sb[$];

   int checks = 0;
   int fails  = 0;

   ex_operand_stage dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_alu_op(in_alu_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
      .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm), .in_pc(in_pc),
      .in_a_sel(in_a_sel), .in_b_sel(in_b_sel), .in_wb_en(in_wb_en),
      .ex_fwd_en(ex_fwd_en), .ex_fwd_rd(ex_fwd_rd), .ex_fwd_val(ex_fwd_val), .ex_is_load(ex_is_load),
      .mem_fwd_en(mem_fwd_en), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_val(mem_fwd_val),
      .ex_stall(ex_stall), .flush(flush),
      .alu_op(alu_op), .r1(r1), .r2(r2), .out_valid(out_valid), .out_rd(out_rd),
      .out_wb_en(out_wb_en), .out_pc(out_pc), .bubble(bubble)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Remember what the bench drove at each edge so the monitor knows when a
   // fresh result is due (stall holds, reset clears)
   logic stall_at_edge = 1'b1;
   always @(posedge clk) stall_at_edge = ex_stall | rst;

   // Monitor: each fresh valid result pops one expected entry
   always @(negedge clk) begin
      if (!stall_at_edge && out_valid === 1'b1) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_valid", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_op", 64'(alu_op), 64'(e.op));
            chk("sb_r1", 64'(r1), 64'(e.a));
            chk("sb_r2", 64'(r2), 64'(e.b));
            chk("sb_rd", 64'(out_rd), 64'(e.rd));
            chk("sb_wb", 64'(out_wb_en), 64'(e.wb));
            chk("sb_pc", 64'(out_pc), 64'(e.pc));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 0; in_alu_op = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
      in_rs1_val = 0; in_rs2_val = 0; in_imm = 0; in_pc = 0;
      in_a_sel = 0; in_b_sel = 0; in_wb_en = 0;
      ex_fwd_en = 0; ex_fwd_rd = 0; ex_fwd_val = 0; ex_is_load = 0;
      mem_fwd_en = 0; mem_fwd_rd = 0; mem_fwd_val = 0;
      ex_stall = 0; flush = 0;
   endtask

   task automatic drive(input logic [4:0] op, input logic [4:0] rs1, input logic [31:0] v1,
                        input logic [4:0] rs2, input logic [31:0] v2, input logic [31:0] imm,
                        input logic [31:0] pc, input logic asel, input logic bsel,
                        input logic [4:0] rd);
      in_valid = 1; in_alu_op = op; in_rs1 = rs1; in_rs1_val = v1; in_rs2 = rs2;
      in_rs2_val = v2; in_imm = imm; in_pc = pc; in_a_sel = asel; in_b_sel = bsel;
      in_rd = rd; in_wb_en = 1;
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      e.op = in_alu_op; e.a = a; e.b = b; e.rd = in_rd; e.wb = in_wb_en; e.pc = in_pc;
      sb.push_back(e);
   endtask

   initial begin
      idle();
      // Reset held with a valid instruction present
      rst = 1;
      drive(5'h00, 5'd3, 32'd10, 5'd4, 32'd7, 0, 32'h40, 0, 0, 5'd6);
      tick(); tick();
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_op", 64'(alu_op), 64'(NOP));
      chk("rst_r1", 64'(r1), 64'd0);
      chk("rst_r2", 64'(r2), 64'd0);
      chk("rst_pc", 64'(out_pc), 64'd0);
      chk("rst_bubble", 64'(bubble), 64'd0);
      chk("rst_ready", 64'(in_ready), 64'd0);
      rst = 0; idle();
      tick();

      // Plain issue from register file
      drive(5'h00, 5'd3, 32'd10, 5'd4, 32'd7, 0, 32'h100, 0, 0, 5'd6);
      #1 chk("plain_ready", 64'(in_ready), 64'd1);
      push(32'd10, 32'd7);
      tick();
      idle();
      tick();
      chk("idle_valid", 64'(out_valid), 64'd0);
      chk("idle_op", 64'(alu_op), 64'(NOP));
      chk("idle_pc_hold", 64'(out_pc), 64'h100);

      // EX and MEM both write rs1
      drive(5'h02, 5'd5, 32'd1, 5'd0, 0, 32'd8, 32'h200, 0, 1, 5'd7);
      ex_fwd_en = 1; ex_fwd_rd = 5; ex_fwd_val = 99;
      mem_fwd_en = 1; mem_fwd_rd = 5; mem_fwd_val = 42;
`ifdef FWD_EN
      #1 chk("exfwd_ready", 64'(in_ready), 64'd1);
      push(32'd99, 32'd8);
      tick();
`else
      #1 chk("exfwd_ready0", 64'(in_ready), 64'd0);
      tick();
      chk("exfwd_bubble1", 64'(bubble), 64'd1);
      chk("exfwd_valid1", 64'(out_valid), 64'd0);
      ex_fwd_en = 0;
      #1 chk("exfwd_ready1", 64'(in_ready), 64'd0);
      tick();
      chk("exfwd_bubble2", 64'(bubble), 64'd1);
      mem_fwd_en = 0;
      #1 chk("exfwd_ready2", 64'(in_ready), 64'd1);
      push(32'd1, 32'd8);
      tick();
`endif
      idle();
      tick();

      // Load-use on rs2
      drive(5'h03, 5'd0, 0, 5'd2, 32'd3, 0, 32'h300, 1, 0, 5'd8);
      ex_fwd_en = 1; ex_is_load = 1; ex_fwd_rd = 2;
      #1 chk("lu_ready", 64'(in_ready), 64'd0);
      tick();
      chk("lu_bubble", 64'(bubble), 64'd1);
      chk("lu_valid", 64'(out_valid), 64'd0);
      chk("lu_op", 64'(alu_op), 64'(NOP));
      ex_fwd_en = 0; ex_is_load = 0; mem_fwd_en = 1; mem_fwd_rd = 2; mem_fwd_val = 32'h1234;
`ifdef FWD_EN
      #1 chk("lu_ready2", 64'(in_ready), 64'd1);
      push(32'h300, 32'h1234);
      tick();
      chk("lu_bubble_end", 64'(bubble), 64'd0);
`else
      #1 chk("lu_ready2", 64'(in_ready), 64'd0);
      tick();
      chk("lu_bubble2", 64'(bubble), 64'd1);
      mem_fwd_en = 0;
      push(32'h300, 32'd3);
      tick();
      chk("lu_bubble_end", 64'(bubble), 64'd0);
`endif
      idle();
      tick();

      // x0 reads as zero regardless of rf or writer targeting x0
      drive(5'h04, 5'd0, 32'd77, 5'd0, 0, 32'hFFFF_FFFC, 32'h400, 0, 1, 5'd9);
      ex_fwd_en = 1; ex_fwd_rd = 0; ex_fwd_val = 5;
      #1 chk("x0_ready", 64'(in_ready), 64'd1);
      push(32'd0, 32'hFFFF_FFFC);
      tick();
      // Immediate operand: rs2 matches a loading writer but is unused
      drive(5'h05, 5'd0, 0, 5'd9, 32'd11, 32'hFFFF_FFFC, 32'h500, 1, 1, 5'd10);
      ex_fwd_en = 1; ex_fwd_rd = 9; ex_is_load = 1; ex_fwd_val = 5;
      #1 chk("imm_ready", 64'(in_ready), 64'd1);
      push(32'h500, 32'hFFFF_FFFC);
      tick();
      idle();

      // Stall freezes outputs; flush beats stall
      drive(5'h03, 5'd6, 32'h55, 5'd0, 0, 32'h66, 32'h600, 0, 1, 5'd11);
      push(32'h55, 32'h66);
      tick();
      drive(5'h06, 5'd7, 32'h77, 5'd0, 0, 32'h88, 32'h700, 0, 1, 5'd12);
      ex_stall = 1;
      #1 chk("stall_ready", 64'(in_ready), 64'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_valid", 64'(out_valid), 64'd1);
         chk("stall_op", 64'(alu_op), 64'h3);
         chk("stall_r1", 64'(r1), 64'h55);
         chk("stall_pc", 64'(out_pc), 64'h600);
      end
      flush = 1;
      tick();
      chk("flush_valid", 64'(out_valid), 64'd0);
      chk("flush_op", 64'(alu_op), 64'(NOP));
      chk("flush_r1", 64'(r1), 64'd0);
      flush = 0; ex_stall = 0;
      #1 chk("post_flush_ready", 64'(in_ready), 64'd1);
      push(32'h77, 32'h88);
      tick();
      idle();
      tick(); tick();
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
